// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmp_pkg
// Brief    : Shared constants and helpers for the CMP data-memory arbiter.
// Revision : 1.0
// ============================================================================
package cmp_pkg;

    localparam int ARB_RR         = 0;
    localparam int ARB_FIXED      = 1;
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 64;

    // Node-id width: ceil(log2(n)), never below one bit.
    function automatic int node_id_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin / fixed-priority one-hot arbiter.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_NODES = 4,
    parameter int ID_W      = 2
) (
    input  logic [NUM_NODES-1:0] i_req,
    input  logic [ID_W-1:0]      i_ptr,
    input  logic                 i_fixed,
    output logic [NUM_NODES-1:0] o_grant,
    output logic [ID_W-1:0]      o_grant_id
);

    logic [NUM_NODES-1:0] w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic                 w_found;
    int                   w_idx;

    // Scan NUM_NODES slots starting at the pointer (or at 0 in fixed mode);
    // the first requester wins, so at most one grant bit is ever set.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        for (int k = 0; k < NUM_NODES; k++) begin
            w_idx = i_fixed ? k : (int'(i_ptr) + k);
            if (w_idx >= NUM_NODES) begin
                w_idx = w_idx - NUM_NODES;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found         = 1'b1;
                w_grant[w_idx]  = 1'b1;
                w_grant_id      = ID_W'(w_idx);
            end
        end
    end

    assign o_grant    = w_grant;
    assign o_grant_id = w_grant_id;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cmp_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cmp_dmem_arbiter
// Brief    : Shares one synchronous data-memory port among NUM_NODES cores,
//            stalling losers and returning tagged read data one cycle later.
// Revision : 1.0
// ============================================================================
module cmp_dmem_arbiter
    import cmp_pkg::*;
#(
    parameter int NUM_NODES = 4,
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ARB_MODE  = ARB_RR,
    parameter int ID_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_NODES-1:0]          req_en,
    input  logic [NUM_NODES-1:0]          req_wr,
    input  logic [NUM_NODES*ADDR_W-1:0]   req_addr,
    input  logic [NUM_NODES*DATA_W-1:0]   req_wdata,
    output logic [NUM_NODES-1:0]          node_stall,
    output logic [NUM_NODES-1:0]          grant,
    output logic                          mem_en,
    output logic                          mem_wr_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic                          rd_valid,
    output logic [ID_W-1:0]               rd_node,
    output logic [DATA_W-1:0]             rd_data
);

    localparam logic        C_FIXED    = (ARB_MODE == ARB_FIXED);
    localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NUM_NODES - 1);

    logic [ID_W-1:0]      r_rr_ptr;
    logic                 r_rd_valid;
    logic [ID_W-1:0]      r_rd_node;

    logic [NUM_NODES-1:0] w_grant;
    logic [ID_W-1:0]      w_grant_id;
    logic [ID_W-1:0]      w_ptr_next;
    logic                 w_mem_en;
    logic                 w_wr;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;

    rr_arbiter #(
        .NUM_NODES (NUM_NODES),
        .ID_W      (ID_W)
    ) u_rr_arbiter (
        .i_req      (req_en),
        .i_ptr      (r_rr_ptr),
        .i_fixed    (C_FIXED),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id)
    );

    assign w_mem_en   = |w_grant;
    assign w_ptr_next = (w_grant_id == C_LAST_ID) ? '0 : (w_grant_id + 1'b1);

    // Grant is one-hot, so a priority-free select yields the winner's fields
    // and all-zero when nobody is granted.
    always_comb begin
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (w_grant[i]) begin
                w_wr    = req_wr[i];
                w_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_node  <= '0;
        end else begin
            if (w_mem_en) begin
                r_rr_ptr <= w_ptr_next;
            end
            r_rd_valid <= w_mem_en & ~w_wr;
            if (w_mem_en && !w_wr) begin
                r_rd_node <= w_grant_id;
            end
        end
    end

    assign grant      = w_grant;
    assign node_stall = req_en & ~w_grant;
    assign mem_en     = w_mem_en;
    assign mem_wr_en  = w_wr;
    assign mem_addr   = w_addr;
    assign mem_wdata  = w_wdata;
    assign rd_valid   = r_rd_valid;
    assign rd_node    = r_rd_node;
    assign rd_data    = mem_rdata;

endmodule : cmp_dmem_arbiter
`default_nettype wire

// File: tb/tb_cmp_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmp_dmem_arbiter
// Brief    : Self-checking bench: round-robin and fixed-priority instances
//            driven together and compared against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_cmp_dmem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_en = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [DW-1:0]   mem_rdata = '0;

    logic [N-1:0]    stall_o [2];
    logic [N-1:0]    grant_o [2];
    logic            men_o   [2];
    logic            mwr_o   [2];
    logic [AW-1:0]   maddr_o [2];
    logic [DW-1:0]   mwd_o   [2];
    logic            rv_o    [2];
    logic [1:0]      rn_o    [2];
    logic [DW-1:0]   rd_o    [2];

    int checks = 0;
    int failures = 0;

    // Model state per instance (0 = round-robin, 1 = fixed priority)
    int m_ptr [2];
    bit m_rv  [2];
    int m_rn  [2];

    always #5 clk = ~clk;

    cmp_dmem_arbiter #(.NUM_NODES(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .ID_W(2)) u_rr (
        .clk(clk), .reset(reset), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .node_stall(stall_o[0]),
        .grant(grant_o[0]), .mem_en(men_o[0]), .mem_wr_en(mwr_o[0]),
        .mem_addr(maddr_o[0]), .mem_wdata(mwd_o[0]), .mem_rdata(mem_rdata),
        .rd_valid(rv_o[0]), .rd_node(rn_o[0]), .rd_data(rd_o[0]));

    cmp_dmem_arbiter #(.NUM_NODES(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .ID_W(2)) u_fx (
        .clk(clk), .reset(reset), .req_en(req_en), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .node_stall(stall_o[1]),
        .grant(grant_o[1]), .mem_en(men_o[1]), .mem_wr_en(mwr_o[1]),
        .mem_addr(maddr_o[1]), .mem_wdata(mwd_o[1]), .mem_rdata(mem_rdata),
        .rd_valid(rv_o[1]), .rd_node(rn_o[1]), .rd_data(rd_o[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner under the stated rules: scan from the pointer (or node 0 when fixed).
    function automatic int pick(input int mode, input logic [N-1:0] en, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mode == 1) ? k : (ptr + k) % N;
            if (en[j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ptr[i] = 0;
            m_rv[i]  = 1'b0;
            m_rn[i]  = 0;
        end
    endfunction

    task automatic set_req(input int n, input bit en, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_en[n]              = en;
        req_wr[n]              = wr;
        req_addr[n*AW +: AW]   = a;
        req_wdata[n*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_en = '0;
        req_wr = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // One cycle: check both instances at the falling edge, then advance the model.
    task automatic step(output int g_rr);
        int g [2];
        logic [N-1:0] gv;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            g[i] = pick(i, req_en, m_ptr[i]);
            gv = (g[i] < 0) ? '0 : (N'(1) << g[i]);
            chk($sformatf("grant[%0d]", i), 64'(grant_o[i]), 64'(gv));
            chk($sformatf("stall[%0d]", i), 64'(stall_o[i]), 64'(req_en & ~gv));
            chk($sformatf("mem_en[%0d]", i), 64'(men_o[i]), 64'(g[i] >= 0));
            chk($sformatf("mem_wr[%0d]", i), 64'(mwr_o[i]), (g[i] >= 0) ? 64'(req_wr[g[i]]) : 64'd0);
            chk($sformatf("mem_addr[%0d]", i), 64'(maddr_o[i]),
                (g[i] >= 0) ? 64'(req_addr[g[i]*AW +: AW]) : 64'd0);
            chk($sformatf("mem_wdata[%0d]", i), mwd_o[i],
                (g[i] >= 0) ? req_wdata[g[i]*DW +: DW] : 64'd0);
            chk($sformatf("rd_valid[%0d]", i), 64'(rv_o[i]), 64'(m_rv[i]));
            if (m_rv[i]) begin
                chk($sformatf("rd_node[%0d]", i), 64'(rn_o[i]), 64'(m_rn[i]));
                chk($sformatf("rd_data[%0d]", i), rd_o[i], mem_rdata);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = (g[i] >= 0) && !req_wr[g[i]];
            if (m_rv[i]) m_rn[i] = g[i];
            if (g[i] >= 0) m_ptr[i] = (g[i] + 1) % N;
        end
        g_rr = g[0];
        #1;
    endtask

    initial begin
        int g;
        int seq [8];
        model_reset();
        do_reset();

        // Idle after reset
        step(g);
        chk("idle_grant", 64'(grant_o[0]), 64'd0);

        // Node 2 read of 0x40, data returned next cycle
        set_req(2, 1'b1, 1'b0, 32'h40, 64'd0);
        step(g);
        chk("n2_granted", 64'(g), 64'd2);
        req_en = '0;
        mem_rdata = 64'hDEADBEEF_00000001;
        step(g);

        // All four requesting from reset: 0,1,2,3,0,1,2,3
        do_reset();
        for (int n = 0; n < N; n++) set_req(n, 1'b1, 1'b0, 32'(n * 16), 64'(n));
        for (int c = 0; c < 8; c++) begin
            mem_rdata = {$urandom, $urandom};
            step(g);
            seq[c] = g;
        end
        for (int c = 0; c < 8; c++) chk($sformatf("rr_seq%0d", c), 64'(seq[c]), 64'(c % N));

        // Nodes 1 and 3 requesting: fixed instance always picks 1
        do_reset();
        req_en = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            step(g);
            chk("fx_stall3", 64'(stall_o[1][3]), 64'd1);
        end

        // Pointer at 1: node 0 write vs node 1 read
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h8, 64'd0);
        step(g);
        set_req(0, 1'b1, 1'b1, 32'h10, 64'h55);
        set_req(1, 1'b1, 1'b0, 32'h20, 64'd0);
        step(g);
        chk("wr_vs_rd_first", 64'(g), 64'd1);
        req_en[1] = 1'b0;
        mem_rdata = {$urandom, $urandom};
        step(g);
        chk("wr_second", 64'(g), 64'd0);
        req_en = '0;
        step(g);

        // Reset asserted mid-cycle right after a read grant
        do_reset();
        set_req(0, 1'b1, 1'b0, 32'h4, 64'd0);
        step(g);
        req_en = 4'b0100;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        model_reset();
        req_en = 4'b1010;
        step(g);
        chk("post_reset_lowest", 64'(g), 64'd1);

        // Randomized traffic honouring the stall contract of the RR instance
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] held;
            held = stall_o[0];
            for (int n = 0; n < N; n++) begin
                if (!held[n]) begin
                    set_req(n, ($urandom_range(0, 99) < 60), $urandom_range(0, 1) == 1,
                            $urandom, {$urandom, $urandom});
                end
            end
            mem_rdata = {$urandom, $urandom};
            if (c == 200) begin
                req_en = '1;
                req_wr = '0;
            end
            step(g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cmp_dmem_arbiter
`default_nettype wire

// File: doc/cmp_dmem_arbiter.md
Name: cmp_dmem_arbiter

Overview:
- Parametrised shared data-memory arbiter for an N-node chip multiprocessor.
- Lets NUM_NODES four-stage processor cores share one synchronous data-memory port.
- Selects at most one request per cycle (round-robin or fixed priority), stalls the losers, and returns read data one cycle later, tagged with the requesting node.
- Sits between the per-node memEn/memWrEn/addr_out/d_out outputs of each core and a single data memory.

Parameters:
- NUM_NODES, 4, number of processor nodes (2..16).
- ADDR_W, 32, address width.
- DATA_W, 64, data width.
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (node 0 highest).
- ID_W, 2, node-id width; must equal ceil(log2(NUM_NODES)), minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_en  in  NUM_NODES  per-node memory enable (core memEn).
- req_wr  in  NUM_NODES  per-node write enable (core memWrEn); ignored when req_en is low.
- req_addr  in  NUM_NODES*ADDR_W  flattened addresses; node i occupies slice i.
- req_wdata  in  NUM_NODES*DATA_W  flattened write data; node i occupies slice i.
- node_stall  out  NUM_NODES  high = node requested this cycle and was not granted.
- grant  out  NUM_NODES  one-hot grant for this cycle (all zero when idle).
- mem_en  out  1  shared memory enable.
- mem_wr_en  out  1  shared memory write enable.
- mem_addr  out  ADDR_W  shared memory address.
- mem_wdata  out  DATA_W  shared memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read enable.
- rd_valid  out  1  read data on rd_data belongs to node rd_node.
- rd_node  out  ID_W  id of the node owning rd_data.
- rd_data  out  DATA_W  returned read data (mem_rdata passed through).

Behaviour:
- Grant logic:
  - Combinational from req_en and the registered pointer rr_ptr.
  - ARB_MODE=0: the first requesting node found searching upward from rr_ptr, wrapping NUM_NODES-1 -> 0.
  - ARB_MODE=1: the lowest-index requesting node; rr_ptr is ignored.
- rr_ptr update:
  - On any grant to node k, rr_ptr <= (k+1) mod NUM_NODES.
  - Unchanged when no request is present.
  - Also updated when ARB_MODE=1, but has no effect there.
- grant is one-hot or zero; never more than one bit set.
- node_stall[i] = req_en[i] & ~grant[i], purely combinational, same cycle.
- Stall contract:
  - A stalled node holds req_en, req_wr, req_addr and req_wdata stable until granted.
  - The block does not latch requests.
- Memory port drive:
  - mem_en = |grant.
  - mem_wr_en, mem_addr and mem_wdata are muxed from the granted node.
  - With no grant, mem_wr_en, mem_addr and mem_wdata are driven to 0.
- Read return:
  - A read granted in cycle T gives rd_valid=1 in cycle T+1, with rd_node = the granted id registered at T.
  - rd_data = mem_rdata in cycle T+1 (combinational pass-through).
  - Writes never raise rd_valid.
- Back-to-back reads to different nodes:
  - Allowed every cycle; rd_valid stays high continuously.
  - rd_node changes each cycle.
- Simultaneous requests from all nodes, round-robin: each node is granted exactly once in any NUM_NODES consecutive cycles; no starvation.
- Write latency: a write grant commits in the same cycle (memory samples on the next edge); the writer's stall drops that cycle.
- Reset (asynchronous, any time):
  - rr_ptr=0, rd_valid=0, rd_node=0.
  - A read granted in the cycle reset asserts is dropped; rd_valid does not fire after reset releases.
  - Combinational outputs follow inputs, with the pointer at 0.
- When rd_valid=0, rd_data is don't-care; the bench must not check it.

Decomposition:
- Shared package cmp_pkg holds:
  - ARB_RR and ARB_FIXED mode constants;
  - a function for the node-id width (clog2 with minimum 1);
  - the default ADDR_W and DATA_W constants shared with the processor wrapper.
- One natural sub-module, rr_arbiter: a NUM_NODES-wide request vector, rr_ptr and mode in; a one-hot grant and an encoded grant id out.
- The top level holds the pointer register, the memory muxes and the read-return register.

Test Plan:
- Reset, then idle → grant=0000, mem_en=0, rd_valid=0, node_stall=0000.
- Node 2 read of addr 0x40, mem_rdata=0xDEADBEEF_00000001 next cycle → grant=0100, mem_en=1, mem_wr_en=0; next cycle rd_valid=1, rd_node=2, rd_data matches.
- Round-robin with all four req_en high for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; each node stalled 3 of every 4 cycles.
- ARB_MODE=1, nodes 1 and 3 both requesting for 3 cycles → node 1 granted every cycle, node_stall[3]=1 throughout.
- Node 0 write (addr 0x10, data 0x55) in the same cycle node 1 reads, pointer at 1 → node 1 granted first and node 0 stalled; next cycle node 0 write granted, mem_wr_en=1, rd_valid=1 for node 1.
- Reset asserted mid-cycle right after a read grant → rd_valid stays 0 after release and rr_ptr returns to 0 (next grant to the lowest requester).
